// File: rtl/seq_pkg.sv
// seq_pkg: shared FSM state type and default sizing for the burst sequence generator
package seq_pkg;
  typedef enum logic {IDLE, SHIFT} state_t;
  localparam int DEF_WIDTH = 16;
  localparam int DEF_RUN = 4;
endpackage

// File: rtl/run_tracker.sv
// run_tracker: tracks the current run of equal serial bits and flags when it reaches RUN
module run_tracker #(
  parameter int RUN = seq_pkg::DEF_RUN
) (
  input  logic clk,
  input  logic reset_n,
  input  logic w,
  input  logic w_valid,
  output logic z_exp
);
  localparam int RW = $clog2(RUN + 1);
  logic [RW-1:0] run_cnt;
  logic last_bit;
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      run_cnt <= '0;
      last_bit <= 1'b0;
    end else if (!w_valid) begin
      run_cnt <= '0;
    end else begin
      last_bit <= w;
      run_cnt <= (run_cnt != '0 && w == last_bit) ? (run_cnt == RW'(RUN) ? run_cnt : run_cnt + 1'b1) : RW'(1);
    end
  assign z_exp = run_cnt == RW'(RUN);
endmodule

// File: rtl/seq_generator.sv
// seq_generator: serialises a loaded burst MSB-first and predicts the run detector output
module seq_generator
  import seq_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int RUN = DEF_RUN
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     load_valid,
  output logic                     load_ready,
  input  logic [WIDTH-1:0]         load_data,
  input  logic [$clog2(WIDTH):0]   load_len,
  output logic                     w,
  output logic                     w_valid,
  output logic                     z_exp,
  output logic                     done
);
  localparam int LW = $clog2(WIDTH) + 1;
  state_t state;
  logic [WIDTH-1:0] sr, aligned;
  logic [LW-1:0] cnt, eff_len;
  assign eff_len = (load_len == '0 || load_len > LW'(WIDTH)) ? LW'(WIDTH) : load_len;
  // left-align the burst so the first bit always sits at the register MSB
  assign aligned = load_data << (LW'(WIDTH) - eff_len);
  assign load_ready = state == IDLE;
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      state <= IDLE;
      sr <= '0;
      cnt <= '0;
      w <= 1'b0;
      w_valid <= 1'b0;
      done <= 1'b0;
    end else begin
      done <= 1'b0;
      if (state == IDLE) begin
        if (load_valid) begin
          state <= SHIFT;
          w <= aligned[WIDTH-1];
          w_valid <= 1'b1;
          sr <= aligned << 1;
          cnt <= eff_len - 1'b1;
        end
      end else if (cnt == '0) begin
        state <= IDLE;
        w <= 1'b0;
        w_valid <= 1'b0;
        done <= 1'b1;
      end else begin
        w <= sr[WIDTH-1];
        sr <= sr << 1;
        cnt <= cnt - 1'b1;
      end
    end
  run_tracker #(.RUN(RUN)) u_run (
    .clk(clk),
    .reset_n(reset_n),
    .w(w),
    .w_valid(w_valid),
    .z_exp(z_exp)
  );
endmodule

// File: tb/tb_seq_generator.sv
// tb_seq_generator: directed bursts with hand-computed serial, run and handshake expectations
module tb_seq_generator;
  logic clk = 1'b0, reset_n = 1'b0, load_valid = 1'b0;
  logic load_ready, w, w_valid, z_exp, done;
  logic [15:0] load_data = '0;
  logic [4:0] load_len = '0;
  int errors = 0, checks = 0;
  seq_generator dut (
    .clk(clk), .reset_n(reset_n), .load_valid(load_valid), .load_ready(load_ready),
    .load_data(load_data), .load_len(load_len), .w(w), .w_valid(w_valid),
    .z_exp(z_exp), .done(done)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic idle_outs(input string tag);
    chk({tag, "_ready"}, load_ready, 1);
    chk({tag, "_w"}, w, 0);
    chk({tag, "_wv"}, w_valid, 0);
    chk({tag, "_z"}, z_exp, 0);
    chk({tag, "_done"}, done, 0);
  endtask
  // n = effective length, zv[i-1] = z in bit cycle i, zd = z in the done cycle
  task automatic burst(input string tag, input logic [15:0] d, input logic [4:0] len, input int n,
                       input logic [15:0] zv, input logic zd, input bit noisy);
    load_valid = 1; load_data = d; load_len = len;
    chk({tag, "_ready0"}, load_ready, 1);
    tick();
    load_valid = 0;
    for (int i = 1; i <= n; i++) begin
      chk($sformatf("%s_wv%0d", tag, i), w_valid, 1);
      chk($sformatf("%s_w%0d", tag, i), w, d[n-i]);
      chk($sformatf("%s_z%0d", tag, i), z_exp, zv[i-1]);
      chk($sformatf("%s_rdy%0d", tag, i), load_ready, 0);
      chk($sformatf("%s_dn%0d", tag, i), done, 0);
      if (noisy) begin
        load_valid = 1'($urandom); load_data = 16'($urandom); load_len = 5'($urandom);
      end
      tick();
    end
    load_valid = 0;
    chk({tag, "_done"}, done, 1);
    chk({tag, "_donewv"}, w_valid, 0);
    chk({tag, "_donew"}, w, 0);
    chk({tag, "_donerdy"}, load_ready, 1);
    chk({tag, "_donez"}, z_exp, zd);
    tick();
    idle_outs({tag, "_after"});
  endtask
  initial begin
    tick(); tick();
    idle_outs("reset");
    reset_n = 1;
    tick();
    idle_outs("idle");
    burst("b000f", 16'h000F, 5'd8, 8, 16'h0010, 1'b1, 0);
    burst("baaaa", 16'hAAAA, 5'd0, 16, 16'h0000, 1'b0, 0);
    burst("bffff", 16'hFFFF, 5'd6, 6, 16'h0030, 1'b1, 0);
    burst("len1", 16'h0001, 5'd1, 1, 16'h0000, 1'b0, 0);
    burst("clamp", 16'h8001, 5'd17, 16, 16'hFFE0, 1'b0, 0);
    burst("noisy", 16'h0234, 5'd12, 12, 16'h0000, 1'b0, 1);
    // back-to-back: load_valid held high, new burst accepted in the done cycle
    load_valid = 1; load_data = 16'h0007; load_len = 5'd3;
    tick();
    load_data = 16'h0002; load_len = 5'd2;
    for (int i = 1; i <= 3; i++) begin
      chk($sformatf("b2b_w%0d", i), w, 1);
      chk($sformatf("b2b_z%0d", i), z_exp, 0);
      chk($sformatf("b2b_rdy%0d", i), load_ready, 0);
      tick();
    end
    chk("b2b_done", done, 1);
    chk("b2b_donerdy", load_ready, 1);
    chk("b2b_donez", z_exp, 0);
    tick();
    load_valid = 0;
    chk("b2b_n1wv", w_valid, 1);
    chk("b2b_n1w", w, 1);
    chk("b2b_n1dn", done, 0);
    tick();
    chk("b2b_n2w", w, 0);
    chk("b2b_n2wv", w_valid, 1);
    tick();
    chk("b2b_n2done", done, 1);
    tick();
    // reset mid-burst aborts with no done pulse
    load_valid = 1; load_data = 16'h02A5; load_len = 5'd10;
    tick();
    load_valid = 0;
    chk("rst_w1", w, 1);
    tick();
    chk("rst_w2", w, 0);
    tick();
    chk("rst_w3v", w_valid, 1);
    reset_n = 0;
    #1;
    idle_outs("rst_async");
    tick();
    idle_outs("rst_hold");
    reset_n = 1;
    tick();
    idle_outs("rst_rel");
    burst("rst_new", 16'h02A5, 5'd10, 10, 16'h0000, 1'b0, 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
